pshpul_seq: RTL and testbench

Multi-cycle sequencer for the 6809 PSHS/PSHU/PULS/PULU instructions. It walks the postbyte register mask and issues one memory byte access per cycle-handshake. For each byte it drives the register selector (RN code plus high/low byte) to the register-file/bus datapath. It sits between the opcode decode (which supplies `use_s` and the stack pointer) and the memory bus interface, and returns the updated stack pointer on completion.

---
 rtl/pshpul_seq_pkg.sv | 46 ++++
 rtl/pshpul_seq_prio_enc.sv | 25 ++
 rtl/pshpul_seq.sv | 117 +++++++++++
 tb/tb_pshpul_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pshpul_seq_pkg.sv
// pshpul_seq_pkg: shared state encodings, postbyte bit positions and register codes for the PSH/PUL sequencer
package pshpul_seq_pkg;

    typedef enum logic [1:0] {
        PP_IDLE   = 2'd0,
        PP_DEAD   = 2'd1,
        PP_ACCESS = 2'd2,
        PP_FINISH = 2'd3
    } pp_state_e;

    localparam int PPB_CC = 0;
    localparam int PPB_A  = 1;
    localparam int PPB_B  = 2;
    localparam int PPB_DP = 3;
    localparam int PPB_X  = 4;
    localparam int PPB_Y  = 5;
    localparam int PPB_US = 6;
    localparam int PPB_PC = 7;

    localparam logic [3:0] RN_ACCD = 4'h0;
    localparam logic [3:0] RN_IX   = 4'h1;
    localparam logic [3:0] RN_IY   = 4'h2;
    localparam logic [3:0] RN_U    = 4'h3;
    localparam logic [3:0] RN_S    = 4'h4;
    localparam logic [3:0] RN_PC   = 4'h5;
    localparam logic [3:0] RN_ACCA = 4'h8;
    localparam logic [3:0] RN_ACCB = 4'h9;
    localparam logic [3:0] RN_CC   = 4'hA;
    localparam logic [3:0] RN_DP   = 4'hB;
    localparam logic [3:0] RN_INV  = 4'hF;

    // Bit 6 names the stack opposite the one being used
    function automatic logic [3:0] pp_reg_code(input logic [2:0] bit_idx, input logic use_s);
        case (bit_idx)
            3'(PPB_PC): pp_reg_code = RN_PC;
            3'(PPB_US): pp_reg_code = use_s ? RN_U : RN_S;
            3'(PPB_Y):  pp_reg_code = RN_IY;
            3'(PPB_X):  pp_reg_code = RN_IX;
            3'(PPB_DP): pp_reg_code = RN_DP;
            3'(PPB_B):  pp_reg_code = RN_ACCB;
            3'(PPB_A):  pp_reg_code = RN_ACCA;
            default:    pp_reg_code = RN_CC;
        endcase
    endfunction

endpackage

// File: rtl/pshpul_seq_prio_enc.sv
// pshpul_prio_enc: picks the next postbyte bit (highest for push, lowest for pull) and flags 16-bit registers
module pshpul_prio_enc
    import pshpul_seq_pkg::*;
(
    input  logic [7:0] mask,
    input  logic       pull,
    output logic [2:0] idx,
    output logic       any,
    output logic       is16
);

    // Later matches override earlier ones, so scan order sets the priority
    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!pull && mask[i])
                idx = 3'(i);
            if (pull && mask[7-i])
                idx = 3'(7 - i);
        end
        any  = |mask;
        is16 = idx >= 3'(PPB_X);
    end

endmodule

// File: rtl/pshpul_seq.sv
// pshpul_seq: 6809 PSHS/PSHU/PULS/PULU byte sequencer; PSHPUL_CYCLE_EXACT_EN adds a dead cycle before the first access
module pshpul_seq
    import pshpul_seq_pkg::*;
(
    input  logic        cpu_clk,
    input  logic        cpu_reset_n,
    input  logic        start,
    input  logic        is_pull,
    input  logic        use_s,
    input  logic [7:0]  mask,
    input  logic [15:0] sp_in,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic        mem_re,
    input  logic        mem_ack,
    output logic [3:0]  reg_sel,
    output logic        byte_hi,
    output logic        busy,
    output logic        done,
    output logic [15:0] sp_out
);

    pp_state_e   state_q, state_d;
    logic [7:0]  mask_q, mask_d;
    logic [15:0] ptr_q, ptr_d;
    logic        pull_q, pull_d;
    logic        use_s_q, use_s_d;
    logic        second_q, second_d;
    logic [2:0]  idx;
    logic        any;
    logic        is16;
    logic        strobe;
    logic        xfer;
    logic        last_byte;

    pshpul_prio_enc u_enc (
        .mask (mask_q),
        .pull (pull_q),
        .idx  (idx),
        .any  (any),
        .is16 (is16)
    );

    assign strobe    = state_q == PP_ACCESS && any;
    assign xfer      = strobe && mem_ack;
    assign last_byte = !is16 || second_q;

    // State and operand registers
    always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            state_q  <= PP_IDLE;
            mask_q   <= 8'd0;
            ptr_q    <= 16'd0;
            pull_q   <= 1'b0;
            use_s_q  <= 1'b0;
            second_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            ptr_q    <= ptr_d;
            pull_q   <= pull_d;
            use_s_q  <= use_s_d;
            second_q <= second_d;
        end
    end

    // Latch the request, then step pointer, byte phase and mask on each acknowledged byte
    always_comb begin
        mask_d   = mask_q;
        ptr_d    = ptr_q;
        pull_d   = pull_q;
        use_s_d  = use_s_q;
        second_d = second_q;
        if (state_q == PP_IDLE && start) begin
            mask_d   = mask;
            ptr_d    = sp_in;
            pull_d   = is_pull;
            use_s_d  = use_s;
            second_d = 1'b0;
        end else if (xfer) begin
            ptr_d    = pull_q ? ptr_q + 16'd1 : ptr_q - 16'd1;
            second_d = !last_byte;
            if (last_byte)
                mask_d[idx] = 1'b0;
        end
    end

    // Next state; ACCESS ends once the mask will be empty after this cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            PP_IDLE:
                if (start)
`ifdef PSHPUL_CYCLE_EXACT_EN
                    state_d = PP_DEAD;
`else
                    state_d = PP_ACCESS;
`endif
            PP_DEAD:   state_d = PP_ACCESS;
            PP_ACCESS: state_d = mask_d == 8'd0 ? PP_FINISH : PP_ACCESS;
            default:   state_d = PP_IDLE;
        endcase
    end

    // Bus strobes, register selector and completion outputs
    always_comb begin
        mem_we   = strobe && !pull_q;
        mem_re   = strobe && pull_q;
        mem_addr = strobe ? (pull_q ? ptr_q : ptr_q - 16'd1) : 16'd0;
        reg_sel  = strobe ? pp_reg_code(idx, use_s_q) : RN_INV;
        byte_hi  = strobe && is16 && (pull_q ? !second_q : second_q);
        busy     = state_q != PP_IDLE;
        done     = state_q == PP_FINISH;
        sp_out   = done ? ptr_q : 16'd0;
    end

endmodule

// File: tb/tb_pshpul_seq.sv
// tb_pshpul_seq: randomized self-checking bench for pshpul_seq against a transaction-list model
module tb_pshpul_seq;
    import pshpul_seq_pkg::*;

`ifdef PSHPUL_CYCLE_EXACT_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    typedef struct {
        logic [15:0] addr;
        logic [3:0]  sel;
        logic        hi;
    } xfer_t;

    logic        cpu_clk = 1'b0;
    logic        cpu_reset_n = 1'b0;
    logic        start = 1'b0;
    logic        is_pull = 1'b0;
    logic        use_s = 1'b0;
    logic [7:0]  mask = 8'd0;
    logic [15:0] sp_in = 16'd0;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic        mem_re;
    logic [3:0]  reg_sel;
    logic        byte_hi;
    logic        busy;
    logic        done;
    logic [15:0] sp_out;

    int    n_chk = 0;
    int    n_fail = 0;
    xfer_t exp_q[$];

    pshpul_seq dut (
        .cpu_clk     (cpu_clk),
        .cpu_reset_n (cpu_reset_n),
        .start       (start),
        .is_pull     (is_pull),
        .use_s       (use_s),
        .mask        (mask),
        .sp_in       (sp_in),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_ack     (mem_ack),
        .reg_sel     (reg_sel),
        .byte_hi     (byte_hi),
        .busy        (busy),
        .done        (done),
        .sp_out      (sp_out)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_code(input int b, input bit us);
        case (b)
            7:       return RN_PC;
            6:       return us ? RN_U : RN_S;
            5:       return RN_IY;
            4:       return RN_IX;
            3:       return RN_DP;
            2:       return RN_ACCB;
            1:       return RN_ACCA;
            default: return RN_CC;
        endcase
    endfunction

    // One instruction: build the expected byte list, then drive and check it cycle by cycle
    task automatic run_op(input bit pl, input bit us, input logic [7:0] m, input logic [15:0] sp,
                          input int lat, input bit poke);
        xfer_t       e;
        logic [15:0] p;
        int          b, nby, nb, w;
        bit          fin;
        exp_q.delete();
        p = sp;
        for (int k = 0; k < 8; k++) begin
            b = pl ? k : 7 - k;
            if (m[b]) begin
                nby = b >= 4 ? 2 : 1;
                for (int j = 0; j < nby; j++) begin
                    e.sel = exp_code(b, us);
                    e.hi  = nby == 2 && (pl ? j == 0 : j == 1);
                    if (pl) begin
                        e.addr = p;
                        p = p + 16'd1;
                    end else begin
                        p = p - 16'd1;
                        e.addr = p;
                    end
                    exp_q.push_back(e);
                end
            end
        end
        nb = exp_q.size();
        @(negedge cpu_clk);
        start = 1'b1; is_pull = pl; use_s = us; mask = m; sp_in = sp; mem_ack = 1'b0;
        w = 0;
        fin = 1'b0;
        for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
            @(negedge cpu_clk);
            if (cyc == 1) begin
                start = 1'b0;
                mask = 8'($urandom);
                sp_in = 16'($urandom);
                is_pull = 1'($urandom);
                use_s = 1'($urandom);
            end
            if (poke && cyc == 3) begin
                check("poke_busy", busy, 1);
                start = 1'b1;
            end
            if (poke && cyc == 4)
                start = 1'b0;
            if (mem_we || mem_re) begin
                if (exp_q.size() == 0) begin
                    check("extra_strobe", {mem_we, mem_re}, 0);
                    mem_ack = 1'b0;
                end else begin
                    check("we", mem_we, !pl);
                    check("re", mem_re, pl);
                    check("addr", mem_addr, exp_q[0].addr);
                    check("sel", reg_sel, exp_q[0].sel);
                    check("hi", byte_hi, exp_q[0].hi);
                    if (w == lat) begin
                        mem_ack = 1'b1;
                        w = 0;
                        void'(exp_q.pop_front());
                    end else begin
                        mem_ack = 1'b0;
                        w++;
                    end
                end
            end else begin
                mem_ack = 1'($urandom);
            end
            if (done) begin
                fin = 1'b1;
                check("bytes_left", exp_q.size(), 0);
                check("sp_out", sp_out, p);
                check("busy_at_done", busy, 1);
                if (lat == 0)
                    check("done_cycle", cyc, (nb == 0 ? 1 : nb) + 1 + EXTRA);
            end
        end
        if (!fin)
            check("timeout_done", done, 1);
        mem_ack = 1'b0;
        @(negedge cpu_clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
    endtask

    initial begin
        #12;
        check("rst_we", mem_we, 0);
        check("rst_re", mem_re, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_sp_out", sp_out, 0);
        check("rst_sel", reg_sel, RN_INV);
        check("rst_hi", byte_hi, 0);
        @(negedge cpu_clk);
        cpu_reset_n = 1'b1;

        run_op(1'b0, 1'b1, 8'h81, 16'h0200, 0, 1'b0);
        run_op(1'b1, 1'b0, 8'h40, 16'h1000, 0, 1'b0);
        run_op(1'b0, 1'b1, 8'h00, 16'h3456, 0, 1'b0);
        run_op(1'b1, 1'b1, 8'h00, 16'hABCD, 0, 1'b0);
        run_op(1'b0, 1'b0, 8'h02, 16'h0000, 0, 1'b0);
        run_op(1'b1, 1'b1, 8'h80, 16'hFFFF, 0, 1'b0);
        run_op(1'b0, 1'b1, 8'hFF, 16'h0400, 3, 1'b1);
        run_op(1'b1, 1'b0, 8'hFF, 16'h0400, 3, 1'b1);

        // Reset during the second byte of PSHS 0xFF
        @(negedge cpu_clk);
        start = 1'b1; is_pull = 1'b0; use_s = 1'b1; mask = 8'hFF; sp_in = 16'h0400; mem_ack = 1'b1;
        @(negedge cpu_clk);
        start = 1'b0;
        repeat (EXTRA) @(negedge cpu_clk);
        @(negedge cpu_clk);
        check("rst_mid_sel", reg_sel, RN_PC);
        check("rst_mid_hi", byte_hi, 1);
        check("rst_mid_addr", mem_addr, 16'h03FE);
        #1 cpu_reset_n = 1'b0;
        #1;
        check("rst_mid_we", mem_we, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        @(negedge cpu_clk);
        cpu_reset_n = 1'b1;
        mem_ack = 1'b0;
        repeat (2) @(negedge cpu_clk);
        check("post_rst_done", done, 0);
        check("post_rst_busy", busy, 0);
        run_op(1'b0, 1'b1, 8'hFF, 16'h0400, 0, 1'b0);

        for (int r = 0; r < 40; r++)
            run_op(1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
